instr_sequencer: RTL and testbench

- Programmable stimulus sequencer sitting directly upstream of the single-cycle datapath top (PC).
- Drives its instruction address and its RegWrite/MemWrite controls from a small step table.
- Holds each step for a fixed dwell time.
- Samples the datapath's register-file and data-memory probe outputs at the end of each step, so bring-up runs without a hand-written bench.

---
 rtl/instr_sequencer.sv | 164 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: programmable stimulus sequencer for single-cycle datapath
// bring-up. A small step table drives instr_a / reg_write / mem_write. Each
// step is held for DWELL cycles. The datapath probes are captured on the last
// cycle of every step.
//
// Handshake: start is a single-cycle request. It is accepted only when busy=0.
// halt is accepted only when busy=1. cap_valid is a one-cycle qualifier for
// cap_rf/cap_dm and has no back-pressure.
//
// Optional build macro INSTR_SEQUENCER_STEP_EN adds the step_mode/step_go
// inputs. With step_mode=1 the sequencer pauses after each step's capture and
// waits for a step_go pulse.
module instr_sequencer #(
  parameter int NUM_STEPS = 8,
  parameter int DWELL     = 10,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [2:0]        prog_idx,
  input  logic [4:0]        prog_data,
  input  logic              start,
  input  logic              halt,
`ifdef INSTR_SEQUENCER_STEP_EN
  input  logic              step_mode,
  input  logic              step_go,
`endif
  input  logic [DATA_W-1:0] probe_rf,
  input  logic [DATA_W-1:0] probe_dm,
  output logic [2:0]        instr_a,
  output logic              reg_write,
  output logic              mem_write,
  output logic              busy,
  output logic              done,
  output logic [2:0]        step_idx,
  output logic [DATA_W-1:0] cap_rf,
  output logic [DATA_W-1:0] cap_dm,
  output logic              cap_valid,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] NUM_STEPS_W = 4'(NUM_STEPS);
  localparam logic [2:0] LAST_IDX    = 3'(NUM_STEPS - 1);
  localparam logic [7:0] DWELL_LAST  = 8'(DWELL - 1);

  state_t     state_q;
  logic [7:0] dwell_cnt;
  logic [4:0] step_tab [0:7];

  logic       tbl_wr;
  logic [4:0] entry0;
  logic [4:0] next_entry;
  logic       at_end;
  logic       capture;
  logic       advance;

  assign fsm_state = state_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);

  // Table writes are allowed only while not running, and only to existing entries.
  assign tbl_wr = prog_we && !busy && ({1'b0, prog_idx} < NUM_STEPS_W);

  // A write and a start in the same cycle: step 0 sees the value being written.
  assign entry0     = (tbl_wr && (prog_idx == 3'd0)) ? prog_data : step_tab[0];
  assign next_entry = step_tab[step_idx + 3'd1];

  assign at_end = (state_q == S_RUN) && (dwell_cnt == DWELL_LAST);

`ifdef INSTR_SEQUENCER_STEP_EN
  logic hold_q;
  // Capture once per step; while holding, only step_go moves the run forward.
  assign capture = at_end && !hold_q;
  assign advance = at_end && (hold_q ? step_go : !step_mode);
`else
  assign capture = at_end;
  assign advance = at_end;
`endif

  // Program table storage, cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) step_tab[i] <= '0;
    end else if (tbl_wr) begin
      step_tab[prog_idx] <= prog_data;
    end
  end

  // Sequencer FSM: step/dwell tracking, registered datapath controls, probe capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      dwell_cnt <= '0;
      step_idx  <= '0;
      instr_a   <= '0;
      reg_write <= 1'b0;
      mem_write <= 1'b0;
      cap_rf    <= '0;
      cap_dm    <= '0;
      cap_valid <= 1'b0;
`ifdef INSTR_SEQUENCER_STEP_EN
      hold_q    <= 1'b0;
`endif
    end else begin
      cap_valid <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q                           <= S_RUN;
            step_idx                          <= '0;
            dwell_cnt                         <= '0;
            {instr_a, reg_write, mem_write}   <= entry0;
          end
        end
        S_RUN: begin
          if (halt) begin
            // Abort: drop the write enables at once, no capture.
            state_q   <= S_IDLE;
            reg_write <= 1'b0;
            mem_write <= 1'b0;
            step_idx  <= '0;
            dwell_cnt <= '0;
`ifdef INSTR_SEQUENCER_STEP_EN
            hold_q    <= 1'b0;
`endif
          end else begin
            if (!at_end) dwell_cnt <= dwell_cnt + 8'd1;
            if (capture) begin
              cap_rf    <= probe_rf;
              cap_dm    <= probe_dm;
              cap_valid <= 1'b1;
            end
`ifdef INSTR_SEQUENCER_STEP_EN
            if (advance)                   hold_q <= 1'b0;
            else if (capture && step_mode) hold_q <= 1'b1;
`endif
            if (advance) begin
              if (step_idx != LAST_IDX) begin
                // Next step loads on the same edge, so enables never gap.
                step_idx                        <= step_idx + 3'd1;
                dwell_cnt                       <= '0;
                {instr_a, reg_write, mem_write} <= next_entry;
              end else begin
                // instr_a keeps the last address; enables drop.
                state_q   <= S_DONE;
                reg_write <= 1'b0;
                mem_write <= 1'b0;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer (NUM_STEPS=5, DWELL=10).
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_instr_sequencer;

  logic        clk;
  logic        reset;
  logic        prog_we;
  logic [2:0]  prog_idx;
  logic [4:0]  prog_data;
  logic        start;
  logic        halt;
`ifdef INSTR_SEQUENCER_STEP_EN
  logic        step_mode;
  logic        step_go;
`endif
  logic [31:0] probe_rf;
  logic [31:0] probe_dm;
  logic [2:0]  instr_a;
  logic        reg_write;
  logic        mem_write;
  logic        busy;
  logic        done;
  logic [2:0]  step_idx;
  logic [31:0] cap_rf;
  logic [31:0] cap_dm;
  logic        cap_valid;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;
  int cap_cnt;

  logic [4:0] exp_tab [0:4];

  instr_sequencer #(
    .NUM_STEPS(5),
    .DWELL(10),
    .DATA_W(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .prog_we(prog_we),
    .prog_idx(prog_idx),
    .prog_data(prog_data),
    .start(start),
    .halt(halt),
`ifdef INSTR_SEQUENCER_STEP_EN
    .step_mode(step_mode),
    .step_go(step_go),
`endif
    .probe_rf(probe_rf),
    .probe_dm(probe_dm),
    .instr_a(instr_a),
    .reg_write(reg_write),
    .mem_write(mem_write),
    .busy(busy),
    .done(done),
    .step_idx(step_idx),
    .cap_rf(cap_rf),
    .cap_dm(cap_dm),
    .cap_valid(cap_valid),
    .fsm_state(fsm_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic prog_write(input logic [2:0] idx, input logic [4:0] data);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_idx  = idx;
    prog_data = data;
    @(negedge clk);
    prog_we   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_instr_a"},   32'(instr_a),   32'd0);
    check_eq({tag, "_reg_write"}, 32'(reg_write), 32'd0);
    check_eq({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    check_eq({tag, "_busy"},      32'(busy),      32'd0);
    check_eq({tag, "_done"},      32'(done),      32'd0);
    check_eq({tag, "_step_idx"},  32'(step_idx),  32'd0);
    check_eq({tag, "_cap_rf"},    cap_rf,         32'd0);
    check_eq({tag, "_cap_dm"},    cap_dm,         32'd0);
    check_eq({tag, "_cap_valid"}, 32'(cap_valid), 32'd0);
  endtask

  // Full 5-step run checked every cycle against exp_tab. Also pulses start
  // mid-run (ignored), halt in DONE (ignored), and optionally a table write
  // during the run at cycle wr_cycle (must be ignored).
  task automatic run_full(input int wr_cycle);
    logic [4:0] e;
    logic       cv;
    int         s;
    cap_cnt = 0;
    @(negedge clk);
    start    = 1'b1;
    probe_rf = 32'h100;
    probe_dm = 32'h200;
    for (int k = 1; k <= 55; k++) begin
      @(negedge clk);
      start   = (k == 15);
      halt    = (k == 53);
      prog_we = 1'b0;
      if (k == wr_cycle) begin
        prog_we   = 1'b1;
        prog_idx  = 3'd1;
        prog_data = 5'h1f;
      end
      s  = (k <= 50) ? (k - 1) / 10 : 4;
      e  = exp_tab[s];
      cv = (k > 1) && ((k - 1) % 10 == 0) && (k <= 51);
      check_eq("busy",      32'(busy),      32'(k <= 50));
      check_eq("done",      32'(done),      32'(k > 50));
      check_eq("instr_a",   32'(instr_a),   32'(e[4:2]));
      check_eq("reg_write", 32'(reg_write), (k <= 50) ? 32'(e[1]) : 32'd0);
      check_eq("mem_write", 32'(mem_write), (k <= 50) ? 32'(e[0]) : 32'd0);
      if (k <= 50) check_eq("step_idx", 32'(step_idx), 32'(s));
      check_eq("cap_valid", 32'(cap_valid), 32'(cv));
      if (cap_valid) cap_cnt++;
      if (cv) begin
        check_eq("cap_rf", cap_rf, 32'h100 + 32'(k - 1));
        check_eq("cap_dm", cap_dm, 32'h200 + 32'(k - 1));
      end
      probe_rf = 32'h100 + 32'(k);
      probe_dm = 32'h200 + 32'(k);
    end
    prog_we = 1'b0;
    halt    = 1'b0;
    check_eq("cap_pulse_count", 32'(cap_cnt), 32'd5);
  endtask

  initial begin
    // Reset and idle inputs
    reset     = 1'b0;
    prog_we   = 1'b0;
    prog_idx  = 3'd0;
    prog_data = 5'd0;
    start     = 1'b0;
    halt      = 1'b0;
`ifdef INSTR_SEQUENCER_STEP_EN
    step_mode = 1'b0;
    step_go   = 1'b0;
`endif
    probe_rf  = 32'h0;
    probe_dm  = 32'h0;
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    check_eq("rst_state", 32'(fsm_state), 32'd0);
    reset = 1'b1;

    // Program the table and run it with ramping probes.
    exp_tab[0] = {3'b000, 1'b0, 1'b0};
    exp_tab[1] = {3'b001, 1'b1, 1'b0};
    exp_tab[2] = {3'b010, 1'b0, 1'b1};
    exp_tab[3] = {3'b011, 1'b1, 1'b0};
    exp_tab[4] = {3'b100, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) prog_write(3'(i), exp_tab[i]);
    run_full(0);

`ifdef INSTR_SEQUENCER_STEP_EN
    // Step mode: pause after step 0 capture, advance on step_go.
    @(negedge clk);
    step_mode = 1'b1;
    start     = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      start   = 1'b0;
      step_go = (k == 16);
      halt    = (k == 17);
      if (k == 11) check_eq("step_cap_valid", 32'(cap_valid), 32'd1);
      if (k >= 11 && k <= 16) begin
        check_eq("step_hold_idx",   32'(step_idx), 32'd0);
        check_eq("step_hold_instr", 32'(instr_a),  32'(exp_tab[0][4:2]));
        check_eq("step_hold_busy",  32'(busy),     32'd1);
      end
      if (k >= 12 && k <= 17) check_eq("step_no_recap", 32'(cap_valid), 32'd0);
      if (k == 17) begin
        check_eq("step_go_idx",   32'(step_idx),  32'd1);
        check_eq("step_go_instr", 32'(instr_a),   32'd1);
        check_eq("step_go_rw",    32'(reg_write), 32'd1);
      end
      if (k == 18) check_eq("step_halt_busy", 32'(busy), 32'd0);
    end
    step_go   = 1'b0;
    halt      = 1'b0;
    step_mode = 1'b0;
`endif

    // Halt on cycle 23 of a run.
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      halt  = (k == 23);
      if (k == 23) check_eq("pre_halt_mw", 32'(mem_write), 32'd1);
      if (k == 24) begin
        check_eq("halt_busy",     32'(busy),      32'd0);
        check_eq("halt_done",     32'(done),      32'd0);
        check_eq("halt_rw",       32'(reg_write), 32'd0);
        check_eq("halt_mw",       32'(mem_write), 32'd0);
        check_eq("halt_step_idx", 32'(step_idx),  32'd0);
      end
      if (k >= 24) check_eq("halt_no_cap", 32'(cap_valid), 32'd0);
    end
    halt = 1'b0;

    // Write to entry 1 during a run is ignored; a rerun shows the original.
    run_full(5);
    run_full(0);

    // Writes to entries beyond NUM_STEPS have no effect.
    prog_write(3'd6, 5'h1f);
    prog_write(3'd5, 5'h1f);
    run_full(0);

    // Write and start in the same cycle: the run uses the new entry 0.
    @(negedge clk);
    prog_we   = 1'b1;
    prog_idx  = 3'd0;
    prog_data = 5'b101_1_1;
    start     = 1'b1;
    @(negedge clk);
    prog_we = 1'b0;
    start   = 1'b0;
    check_eq("wrstart_instr", 32'(instr_a),   32'd5);
    check_eq("wrstart_rw",    32'(reg_write), 32'd1);
    check_eq("wrstart_mw",    32'(mem_write), 32'd1);
    check_eq("wrstart_busy",  32'(busy),      32'd1);
    check_eq("wrstart_done",  32'(done),      32'd0);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    check_eq("wrstart_halt_rw", 32'(reg_write), 32'd0);
    check_eq("wrstart_halt_mw", 32'(mem_write), 32'd0);

    // Asynchronous reset in the middle of step 2.
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      start    = 1'b0;
      probe_rf = 32'h100 + 32'(k);
      probe_dm = 32'h200 + 32'(k);
    end
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Table is cleared: the whole run shows address 0 and enables low.
    for (int i = 0; i < 5; i++) exp_tab[i] = 5'd0;
    run_full(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
